// File: rtl/cmos_sensor_emulator_if.sv
// Parallel CMOS sensor bus: control inputs (start/stop/pattern) plus FVAL/LVAL/DATA video outputs.
// The emulator uses the master modport; a capture path or bench uses the slave modport.
interface cmos_sensor_emulator_if #(
  parameter int unsigned DATA_SIZE = 10
) ();
  logic                 iSTART;
  logic                 iEND;
  logic [1:0]           iPATTERN;
  logic [DATA_SIZE-1:0] oDATA;
  logic                 oFVAL;
  logic                 oLVAL;
  logic [15:0]          oX_Cont;
  logic [15:0]          oY_Cont;
  logic [31:0]          oFrame_Cont;
  logic                 oBUSY;

  modport master (
    input  iSTART, iEND, iPATTERN,
    output oDATA, oFVAL, oLVAL, oX_Cont, oY_Cont, oFrame_Cont, oBUSY
  );

  modport slave (
    output iSTART, iEND, iPATTERN,
    input  oDATA, oFVAL, oLVAL, oX_Cont, oY_Cont, oFrame_Cont, oBUSY
  );
endinterface

// File: rtl/cmos_sensor_emulator.sv
// CMOS sensor emulator: frame/line timing generator with deterministic test patterns.
// Optional CMOS_EMU_BORDER_EN forces a 1-pixel all-ones border on every frame.
module cmos_sensor_emulator #(
  parameter int unsigned DATA_SIZE = 10,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned H_BLANK   = 94,
  parameter int unsigned F2L_DLY   = 4,
  parameter int unsigned V_BLANK   = 1000
) (
  input logic                      iCLK,
  input logic                      iRST,
  cmos_sensor_emulator_if.master   bus
);

  localparam logic [15:0] HLast   = 16'(H_ACTIVE - 1);
  localparam logic [15:0] VLast   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] HbLast  = 16'(H_BLANK - 1);
  localparam logic [15:0] F2lLast = 16'(F2L_DLY - 1);
  localparam logic [15:0] VbLast  = 16'(V_BLANK - 1);

  typedef enum logic [2:0] {StIdle, StF2l, StLine, StHblank, StVblank} state_e;

  state_e               state_q, state_d;
  logic                 run_q, run_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          x_q, x_d;
  logic [15:0]          y_q, y_d;
  logic [31:0]          frame_q, frame_d;
  logic [1:0]           pat_q, pat_d;

  // Output stage, one cycle behind the timing state so all video signals stay aligned.
  logic                 fval_q, fval_d;
  logic                 lval_q, lval_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [15:0]          xo_q, xo_d;
  logic [15:0]          yo_q, yo_d;

  always_comb begin
    run_d   = run_q;
    if (bus.iEND) begin
      run_d = 1'b0;
    end else if (bus.iSTART) begin
      run_d = 1'b1;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    pat_d   = pat_q;

    unique case (state_q)
      StIdle: begin
        if (run_q) begin
          state_d = StF2l;
          cnt_d   = '0;
          frame_d = frame_q + 32'd1;
          pat_d   = bus.iPATTERN;
        end
      end
      StF2l: begin
        if (cnt_q == F2lLast) begin
          state_d = StLine;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StLine: begin
        if (x_q == HLast) begin
          state_d = StHblank;
          x_d     = '0;
          cnt_d   = '0;
        end else begin
          x_d = x_q + 16'd1;
        end
      end
      StHblank: begin
        if (cnt_q == HbLast) begin
          cnt_d = '0;
          if (y_q == VLast) begin
            state_d = StVblank;
            y_d     = '0;
          end else begin
            state_d = StLine;
            y_d     = y_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StVblank: begin
        if (cnt_q == VbLast) begin
          cnt_d = '0;
          if (run_q) begin
            state_d = StF2l;
            frame_d = frame_q + 32'd1;
            pat_d   = bus.iPATTERN;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fval_d = (state_q == StF2l) || (state_q == StLine) || (state_q == StHblank);
    lval_d = (state_q == StLine);
    xo_d   = lval_d ? x_q : '0;
    yo_d   = fval_d ? y_q : '0;
    data_d = '0;
    if (lval_d) begin
      unique case (pat_q)
        2'd0: data_d = DATA_SIZE'(x_q);
        2'd1: data_d = DATA_SIZE'(y_q);
        2'd2: data_d = {DATA_SIZE{x_q[3] ^ y_q[3]}};
        2'd3: data_d = DATA_SIZE'(x_q) + DATA_SIZE'(frame_q);
        default: data_d = '0;
      endcase
`ifdef CMOS_EMU_BORDER_EN
      if ((x_q == '0) || (x_q == HLast) || (y_q == '0) || (y_q == VLast)) begin
        data_d = '1;
      end
`else
`endif
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= StIdle;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      pat_q   <= '0;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      data_q  <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      pat_q   <= pat_d;
      fval_q  <= fval_d;
      lval_q  <= lval_d;
      data_q  <= data_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
    end
  end

  assign bus.oDATA       = data_q;
  assign bus.oFVAL       = fval_q;
  assign bus.oLVAL       = lval_q;
  assign bus.oX_Cont     = xo_q;
  assign bus.oY_Cont     = yo_q;
  assign bus.oFrame_Cont = frame_q;
  assign bus.oBUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_cmos_sensor_emulator.sv
// Bench for cmos_sensor_emulator: directed vector table plus random control traffic, both
// checked every cycle against a frame-schedule reference model.
module tb_cmos_sensor_emulator;
  localparam int DW   = 10;
  localparam int H    = 8;
  localparam int V    = 4;
  localparam int HB   = 4;
  localparam int FD   = 2;
  localparam int VB   = 6;
  localparam int FLEN = FD + V * (H + HB);
`ifdef CMOS_EMU_BORDER_EN
  localparam bit Border = 1'b1;
`else
  localparam bit Border = 1'b0;
`endif
  localparam logic [DW-1:0] Ones = '1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmos_sensor_emulator_if #(.DATA_SIZE(DW)) bus ();

  cmos_sensor_emulator #(
    .DATA_SIZE(DW),
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .H_BLANK  (HB),
    .F2L_DLY  (FD),
    .V_BLANK  (VB)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  longint k = 0;

  // Reference model: a frame rises on FVAL when the run request was seen two cycles earlier and
  // the previous frame plus its vertical blanking has fully elapsed.
  bit          m_run;
  bit          m_have;
  longint      m_rise;
  longint      m_earliest;
  int unsigned m_frames;
  logic [1:0]  m_pat;

  logic          e_fval, e_lval, e_busy;
  logic [DW-1:0] e_data;
  logic [15:0]   e_x, e_y;
  logic [31:0]   e_frame;

  function automatic logic [DW-1:0] pix(int x, int y, logic [1:0] p, int unsigned f);
    logic [31:0] xv;
    logic [31:0] yv;
    logic [31:0] s;
    xv = x;
    yv = y;
    s  = xv + f;
`ifdef CMOS_EMU_BORDER_EN
    if (x == 0 || x == H - 1 || y == 0 || y == V - 1) return Ones;
`endif
    case (p)
      2'd0:    return xv[DW-1:0];
      2'd1:    return yv[DW-1:0];
      2'd2:    return (((x / 8) % 2) != ((y / 8) % 2)) ? Ones : '0;
      default: return s[DW-1:0];
    endcase
  endfunction

  task automatic model(input bit r, input bit s, input bit e, input logic [1:0] p);
    bit     run_prev;
    longint t;
    int     u, line, pos;
    if (r) begin
      m_run      = 1'b0;
      m_have     = 1'b0;
      m_frames   = 0;
      m_earliest = k + 2;
    end else begin
      run_prev = m_run;
      m_run    = e ? 1'b0 : (s ? 1'b1 : m_run);
      if (run_prev && (k + 1 >= m_earliest)) begin
        m_have     = 1'b1;
        m_rise     = k + 1;
        m_earliest = k + 1 + FLEN + VB;
        m_frames   = m_frames + 1;
        m_pat      = p;
      end
    end
    e_fval  = 1'b0;
    e_lval  = 1'b0;
    e_data  = '0;
    e_x     = '0;
    e_y     = '0;
    e_frame = m_frames;
    e_busy  = m_have && (k + 1 >= m_rise) && (k < m_rise + FLEN + VB - 1);
    if (m_have && k >= m_rise && k - m_rise < FLEN) begin
      t      = k - m_rise;
      e_fval = 1'b1;
      if (t >= FD) begin
        u    = int'(t) - FD;
        line = u / (H + HB);
        pos  = u % (H + HB);
        e_y  = 16'(line);
        if (pos < H) begin
          e_lval = 1'b1;
          e_x    = 16'(pos);
          e_data = pix(pos, line, m_pat, m_frames);
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit e, input logic [1:0] p);
    logic [76:0] got, want;
    rst          = r;
    bus.iSTART   = s;
    bus.iEND     = e;
    bus.iPATTERN = p;
    @(posedge clk);
    k = k + 1;
    model(r, s, e, p);
    #1;
    got  = {bus.oFVAL, bus.oLVAL, bus.oDATA, bus.oX_Cont, bus.oY_Cont, bus.oFrame_Cont,
            bus.oBUSY};
    want = {e_fval, e_lval, e_data, e_x, e_y, e_frame, e_busy};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL cycle %0d {fval,lval,data,x,y,frame,busy}: got %0b,%0b,%h,%0d,%0d,%0d,%0b want %0b,%0b,%h,%0d,%0d,%0d,%0b",
               k, bus.oFVAL, bus.oLVAL, bus.oDATA, bus.oX_Cont, bus.oY_Cont, bus.oFrame_Cont,
               bus.oBUSY, e_fval, e_lval, e_data, e_x, e_y, e_frame, e_busy);
    end
  endtask

  typedef struct {
    bit            rst;
    bit            start;
    bit            stop;
    logic [1:0]    pat;
    int            cycles;
    bit            fval;
    bit            lval;
    bit            busy;
    int unsigned   frame;
    logic [DW-1:0] data;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit e, logic [1:0] p, int n, bit fv, bit lv, bit b,
                              int unsigned f, logic [DW-1:0] d);
    vec_t v;
    v.rst = r; v.start = s; v.stop = e; v.pat = p; v.cycles = n;
    v.fval = fv; v.lval = lv; v.busy = b; v.frame = f; v.data = d;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [DW-1:0] b0, b7;
    logic [1:0]    rp;
    bit            rr, rs, re;
    b0 = Border ? Ones : DW'(0);
    b7 = Border ? Ones : DW'(7);
    // Frame 1 timing, pattern 0.
    tbl.push_back(mk(1, 0, 0, 0,   2, 0, 0, 0, 0, '0));
    tbl.push_back(mk(0, 1, 0, 0,   1, 0, 0, 0, 0, '0));
    tbl.push_back(mk(0, 0, 0, 0,   1, 0, 0, 1, 1, '0));
    tbl.push_back(mk(0, 0, 0, 0,   1, 1, 0, 1, 1, '0));
    tbl.push_back(mk(0, 0, 0, 0,   2, 1, 1, 1, 1, b0));
    tbl.push_back(mk(0, 0, 0, 0,   7, 1, 1, 1, 1, b7));
    tbl.push_back(mk(0, 0, 0, 0,   1, 1, 0, 1, 1, '0));
    tbl.push_back(mk(0, 0, 0, 0,  39, 1, 0, 1, 1, '0));
    tbl.push_back(mk(0, 0, 0, 0,   1, 0, 0, 1, 1, '0));
    tbl.push_back(mk(0, 0, 0, 0,   5, 0, 0, 1, 2, '0));
    tbl.push_back(mk(0, 0, 0, 0,   1, 1, 0, 1, 2, '0));
    // Stop requested mid frame 2: frame completes, then idle.
    tbl.push_back(mk(0, 0, 0, 0,  19, 1, 1, 1, 2, 10'd5));
    tbl.push_back(mk(0, 0, 1, 0,   1, 1, 1, 1, 2, 10'd6));
    tbl.push_back(mk(0, 0, 0, 0,  29, 1, 0, 1, 2, '0));
    tbl.push_back(mk(0, 0, 0, 0,   1, 0, 0, 1, 2, '0));
    tbl.push_back(mk(0, 0, 0, 0,   5, 0, 0, 0, 2, '0));
    tbl.push_back(mk(0, 0, 0, 0,  20, 0, 0, 0, 2, '0));
    // Start and stop together: stop wins.
    tbl.push_back(mk(0, 1, 1, 0,   1, 0, 0, 0, 2, '0));
    tbl.push_back(mk(0, 0, 0, 0, 100, 0, 0, 0, 2, '0));
    // Reset mid frame 3.
    tbl.push_back(mk(0, 1, 0, 0,   1, 0, 0, 0, 2, '0));
    tbl.push_back(mk(0, 0, 0, 0,  32, 1, 1, 1, 3, 10'd4));
    tbl.push_back(mk(1, 0, 0, 0,   1, 0, 0, 0, 0, '0));
    tbl.push_back(mk(0, 0, 0, 0,  20, 0, 0, 0, 0, '0));
    // Moving ramp, then a mid-frame pattern change that applies from the next frame.
    tbl.push_back(mk(0, 1, 0, 3,   1, 0, 0, 0, 0, '0));
    tbl.push_back(mk(0, 0, 0, 3,   1, 0, 0, 1, 1, '0));
    tbl.push_back(mk(0, 0, 0, 1,  16, 1, 1, 1, 1, 10'd2));
    tbl.push_back(mk(0, 0, 0, 1,  57, 1, 1, 1, 2, 10'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) begin
        step(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].pat);
      end
      checks++;
      if ({bus.oFVAL, bus.oLVAL, bus.oBUSY, bus.oFrame_Cont, bus.oDATA} !==
          {tbl[i].fval, tbl[i].lval, tbl[i].busy, 32'(tbl[i].frame), tbl[i].data}) begin
        errors++;
        $display("FAIL vector %0d {fval,lval,busy,frame,data}: got %0b,%0b,%0b,%0d,%h want %0b,%0b,%0b,%0d,%h",
                 i, bus.oFVAL, bus.oLVAL, bus.oBUSY, bus.oFrame_Cont, bus.oDATA,
                 tbl[i].fval, tbl[i].lval, tbl[i].busy, tbl[i].frame, tbl[i].data);
      end
    end

    // Random control traffic with sparse resets.
    rp = 2'd0;
    step(1'b1, 1'b0, 1'b0, rp);
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(0, 499) == 0);
      rs = ($urandom_range(0, 24) == 0);
      re = ($urandom_range(0, 69) == 0);
      if ($urandom_range(0, 39) == 0) rp = 2'($urandom_range(0, 3));
      step(rr, rs, re, rp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmos_sensor_emulator.md
Name: cmos_sensor_emulator

Overview:
Synthesizable CMOS image-sensor emulator that drives FVAL/LVAL/DATA with the same frame/line timing a parallel-output sensor produces. It feeds the capture path directly, so the full display pipeline can be exercised on-board and in simulation without a physical camera. Frame geometry and blanking are parameters. Pixel content is a selectable deterministic test pattern.

Parameters:
DATA_SIZE, 10, pixel width in bits
H_ACTIVE, 640, pixels per line (LVAL high cycles); range 2..65535
V_ACTIVE, 480, lines per frame; range 2..65535
H_BLANK, 94, LVAL-low cycles after each line; range 1..65535
F2L_DLY, 4, cycles from FVAL rise to first LVAL rise; range 1..65535
V_BLANK, 1000, minimum FVAL-low cycles between frames; range 1..65535

Ports:
iCLK  in  1  pixel clock
iRST  in  1  synchronous reset, active high
iSTART  in  1  pulse: request continuous streaming
iEND  in  1  pulse: stop after current frame
iPATTERN  in  2  0 H-ramp, 1 V-ramp, 2 checker, 3 moving ramp
oDATA  out  DATA_SIZE  pixel data, registered
oFVAL  out  1  frame valid
oLVAL  out  1  line valid
oX_Cont  out  16  column index of current oDATA
oY_Cont  out  16  line index of current line
oFrame_Cont  out  32  frames started since reset
oBUSY  out  1  high while not in IDLE

Behaviour:
- Reset (iRST=1 at an edge): state IDLE, run flag 0, all outputs 0 on the following cycle. Reset mid-frame aborts immediately: FVAL/LVAL drop with no frame completion.
- Run flag: set by iSTART, cleared by iEND. If both are asserted in the same cycle, iEND wins (flag=0). iEND never truncates a frame in progress.
- FSM states: IDLE, F2L, LINE, HBLANK, VBLANK.
  - IDLE -> F2L when run flag=1. oFVAL=1 in the first F2L cycle, i.e. oFVAL rises 2 cycles after the edge that samples iSTART. oFrame_Cont increments (wraps at 2^32) on that transition.
  - F2L: lasts F2L_DLY cycles, oLVAL=0, then -> LINE.
  - LINE: oLVAL=1 for exactly H_ACTIVE cycles. oX_Cont = 0..H_ACTIVE-1. Then -> HBLANK.
  - HBLANK: oLVAL=0 for H_BLANK cycles, oX_Cont=0. Then -> LINE with oY_Cont+1 if oY_Cont<V_ACTIVE-1, else -> VBLANK. oFVAL stays high through the last HBLANK.
  - VBLANK: oFVAL=0, oY_Cont=0, V_BLANK cycles. At the end: run flag=1 -> F2L (next frame, counter increments); run flag=0 -> IDLE.
- FVAL-high length per frame = F2L_DLY + V_ACTIVE*(H_ACTIVE+H_BLANK) cycles exactly.
- oDATA = 0 whenever oLVAL=0. When oLVAL=1, X=oX_Cont and Y=oY_Cont:
  - pattern 0: X[DATA_SIZE-1:0]
  - pattern 1: Y[DATA_SIZE-1:0]
  - pattern 2: all-ones if X[3]^Y[3], else 0
  - pattern 3: (X + oFrame_Cont)[DATA_SIZE-1:0], modulo 2^DATA_SIZE
- iPATTERN is latched at each FVAL rise. Mid-frame changes are ignored.
- oDATA, oLVAL, oFVAL, oX_Cont and oY_Cont are aligned on the same cycle, all driven from registers.
- iSTART while already streaming: no effect. iEND while in IDLE: no effect.

Optional Feature:
CMOS_EMU_BORDER_EN
- Defined: during LINE, pixels with X=0, X=H_ACTIVE-1, Y=0 or Y=V_ACTIVE-1 output all-ones regardless of pattern. This gives a 1-pixel white frame border for checking crop and window alignment downstream.
- Undefined: no override; pattern output only.

Test Plan:
1. Params H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, F2L_DLY=2, V_BLANK=6; pattern 0; pulse iSTART once -> oFVAL rises 2 cycles later and stays high 50 cycles; 4 LVAL pulses of 8 cycles each, separated by 4-cycle gaps; oDATA per line 0..7; oFrame_Cont=1.
2. Same params, iSTART held as a pulse, iEND asserted at cycle 20 of frame 2 -> frame 2 completes (50 FVAL-high cycles), VBLANK of 6 cycles, then IDLE with oBUSY=0; oFrame_Cont=2, no third FVAL rise.
3. iSTART and iEND in the same cycle from IDLE -> no frame starts; oFVAL stays 0 for 100 cycles.
4. iRST asserted at cycle 30 of a frame -> next cycle oFVAL=oLVAL=0, oDATA=0, oFrame_Cont=0, oBUSY=0; no frame restarts until a new iSTART.
5. Pattern 3, DATA_SIZE=10, H_ACTIVE=8 -> frame n line pixels equal (X+n) mod 1024; iPATTERN switched to 1 mid-frame takes effect only from the next FVAL rise (oDATA=Y).
6. With CMOS_EMU_BORDER_EN defined, pattern 1 -> every pixel of lines 0 and 3, and columns 0 and 7, equals 0x3FF; interior pixels equal the Y index.
